// File: rtl/mem_stage_lsu.sv
// Memory stage load/store unit.
// Takes one op per handshake from execute: a load, a store, or an ALU pass-through.
// Memory ops go out on a single-outstanding valid/ack data bus. Byte enables follow the
// access size and lane offset. Load data is sign- or zero-extended. Misaligned, illegal
// and timed-out accesses are reported as precise exceptions with their mcause codes.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_valid / o_stall       op handshake from execute; upstream holds while o_stall is high
//   i_flush                 kills the op being accepted or the result of the one in flight
//   i_load, i_store         op type; neither set (or both set) means pass-through
//   i_funct3                RV access width and signedness
//   i_addr, i_result        effective byte address, ALU result
//   i_wdata                 store data
//   i_rd_addr, i_wb_en      destination register and write-back enable
//   o_valid .. o_wb_en      one-cycle result pulse toward write-back
//   o_exc, o_exc_cause,     exception flag, mcause code and mtval, valid with o_valid
//   o_exc_addr
//   o_dmem_*, i_dmem_*      data-memory bus (lane-aligned address, byte enables)
module mem_stage_lsu #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_stall,
    input  logic                i_flush,
    input  logic                i_load,
    input  logic                i_store,
    input  logic [2:0]          i_funct3,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [XLEN-1:0]     i_result,
    input  logic [XLEN-1:0]     i_wdata,
    input  logic [4:0]          i_rd_addr,
    input  logic                i_wb_en,
    output logic                o_valid,
    output logic [XLEN-1:0]     o_result,
    output logic [4:0]          o_rd_addr,
    output logic                o_wb_en,
    output logic                o_exc,
    output logic [3:0]          o_exc_cause,
    output logic [ADDR_W-1:0]   o_exc_addr,
    output logic                o_dmem_req,
    output logic                o_dmem_we,
    output logic [ADDR_W-1:0]   o_dmem_addr,
    output logic [XLEN-1:0]     o_dmem_wdata,
    output logic [XLEN/8-1:0]   o_dmem_be,
    input  logic                i_dmem_ack,
    input  logic [XLEN-1:0]     i_dmem_rdata
);
    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e state_q, state_d;

    // Transaction context captured at accept time
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [2:0]        f3_q, f3_d;
    logic              store_q, store_d;
    logic [4:0]        rd_q, rd_d;
    logic              wb_q, wb_d;
    logic              kill_q, kill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Bus request registers
    logic              dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [XLEN-1:0]   dmem_wdata_q, dmem_wdata_d;
    logic [NB-1:0]     dmem_be_q, dmem_be_d;

    // Result registers
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;
    logic              wb_out_q, wb_out_d;
    logic              exc_q, exc_d;
    logic [3:0]        cause_q, cause_d;
    logic [ADDR_W-1:0] exc_addr_q, exc_addr_d;

    // Decode of the incoming op
    logic [OFF_W-1:0] off, align_mask;
    logic [7:0]       size_mask;
    logic             is_mem, illegal, misalign, accept;
    logic [XLEN-1:0]  wdata_rep;

    always_comb begin
        off        = i_addr[OFF_W-1:0];
        is_mem     = i_load ^ i_store;
        accept     = (state_q == StIdle) && i_valid && !i_flush;
        illegal    = (i_funct3 == 3'b111) ||
                     ((XLEN == 32) && ((i_funct3 == 3'b011) || (i_funct3 == 3'b110)));
        // Low offset bits that must be zero for this access size
        align_mask = OFF_W'((32'd1 << i_funct3[1:0]) - 32'd1);
        misalign   = |(off & align_mask);
        case (i_funct3[1:0])
            2'd0: begin
                size_mask = 8'h01;
                wdata_rep = {NB{i_wdata[7:0]}};
            end
            2'd1: begin
                size_mask = 8'h03;
                wdata_rep = {(NB / 2){i_wdata[15:0]}};
            end
            2'd2: begin
                size_mask = 8'h0F;
                wdata_rep = {(XLEN / 32){i_wdata[31:0]}};
            end
            default: begin
                size_mask = 8'hFF;
                wdata_rep = i_wdata;
            end
        endcase
    end

    // Load data: bring the addressed lane down to bit 0, then extend
    logic [XLEN-1:0] shifted, load_data;

    always_comb begin
        shifted   = i_dmem_rdata >> {off_q, 3'b000};
        load_data = shifted;
        case (f3_q[1:0])
            2'd0: begin
                load_data       = {XLEN{~f3_q[2] & shifted[7]}};
                load_data[7:0]  = shifted[7:0];
            end
            2'd1: begin
                load_data       = {XLEN{~f3_q[2] & shifted[15]}};
                load_data[15:0] = shifted[15:0];
            end
            2'd2: begin
                load_data       = {XLEN{~f3_q[2] & shifted[31]}};
                load_data[31:0] = shifted[31:0];
            end
            default: load_data = shifted;
        endcase
    end

    // Fires on the TIMEOUT-th WAIT cycle without ack, so req is high exactly TIMEOUT cycles
    logic timeout_hit;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        off_d        = off_q;
        f3_d         = f3_q;
        store_d      = store_q;
        rd_d         = rd_q;
        wb_d         = wb_q;
        kill_d       = kill_q;
        cnt_d        = cnt_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        valid_d      = 1'b0;
        exc_d        = 1'b0;
        result_d     = result_q;
        rd_out_d     = rd_out_q;
        wb_out_d     = wb_out_q;
        cause_d      = cause_q;
        exc_addr_d   = exc_addr_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    rd_out_d = i_rd_addr;
                    if (!is_mem) begin
                        valid_d  = 1'b1;
                        result_d = i_result;
                        wb_out_d = i_wb_en;
                    end else if (illegal || misalign) begin
                        valid_d    = 1'b1;
                        wb_out_d   = 1'b0;
                        exc_d      = 1'b1;
                        cause_d    = illegal ? 4'd2 : (i_store ? 4'd6 : 4'd4);
                        exc_addr_d = i_addr;
                    end else begin
                        state_d      = StWait;
                        cnt_d        = '0;
                        kill_d       = 1'b0;
                        addr_d       = i_addr;
                        off_d        = off;
                        f3_d         = i_funct3;
                        store_d      = i_store;
                        rd_d         = i_rd_addr;
                        wb_d         = i_wb_en;
                        dmem_we_d    = i_store;
                        dmem_addr_d  = {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        dmem_wdata_d = wdata_rep;
                        dmem_be_d    = NB'(size_mask) << off;
                    end
                end
            end
            StWait: begin
                // A flush anywhere in WAIT kills this transaction's result
                if (i_flush) begin
                    kill_d = 1'b1;
                end
                if (i_dmem_ack) begin
                    state_d = StIdle;
                    if (!(kill_q || i_flush)) begin
                        valid_d  = 1'b1;
                        rd_out_d = rd_q;
                        if (store_q) begin
                            wb_out_d = 1'b0;
                        end else begin
                            wb_out_d = wb_q;
                            result_d = load_data;
                        end
                    end
                end else if (timeout_hit) begin
                    state_d = StIdle;
                    if (!(kill_q || i_flush)) begin
                        valid_d    = 1'b1;
                        wb_out_d   = 1'b0;
                        exc_d      = 1'b1;
                        cause_d    = store_q ? 4'd7 : 4'd5;
                        exc_addr_d = addr_q;
                    end
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            off_q        <= '0;
            f3_q         <= '0;
            store_q      <= 1'b0;
            rd_q         <= '0;
            wb_q         <= 1'b0;
            kill_q       <= 1'b0;
            cnt_q        <= '0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_be_q    <= '0;
            valid_q      <= 1'b0;
            result_q     <= '0;
            rd_out_q     <= '0;
            wb_out_q     <= 1'b0;
            exc_q        <= 1'b0;
            cause_q      <= '0;
            exc_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            off_q        <= off_d;
            f3_q         <= f3_d;
            store_q      <= store_d;
            rd_q         <= rd_d;
            wb_q         <= wb_d;
            kill_q       <= kill_d;
            cnt_q        <= cnt_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_be_q    <= dmem_be_d;
            valid_q      <= valid_d;
            result_q     <= result_d;
            rd_out_q     <= rd_out_d;
            wb_out_q     <= wb_out_d;
            exc_q        <= exc_d;
            cause_q      <= cause_d;
            exc_addr_q   <= exc_addr_d;
        end
    end

    assign o_stall      = (state_q != StIdle);
    assign o_dmem_req   = (state_q == StWait);
    assign o_dmem_we    = dmem_we_q;
    assign o_dmem_addr  = dmem_addr_q;
    assign o_dmem_wdata = dmem_wdata_q;
    assign o_dmem_be    = dmem_be_q;
    assign o_valid      = valid_q;
    assign o_result     = result_q;
    assign o_rd_addr    = rd_out_q;
    assign o_wb_en      = wb_out_q;
    assign o_exc        = exc_q;
    assign o_exc_cause  = cause_q;
    assign o_exc_addr   = exc_addr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        exc;
        logic [3:0]  cause;
        logic [63:0] result;
        logic [4:0]  rd;
        logic        wb;
        logic [31:0] eaddr;
    } exp_t;

    exp_t a_q[$];
    exp_t b_q[$];
    exp_t a_e, b_e;

    function automatic exp_t mk(input logic exc, input logic [3:0] cause,
                                input logic [63:0] result, input logic [4:0] rd,
                                input logic wb, input logic [31:0] eaddr);
        exp_t e;
        e.exc = exc; e.cause = cause; e.result = result;
        e.rd = rd; e.wb = wb; e.eaddr = eaddr;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_out(input string tag, input exp_t e, input logic exc,
                           input logic [3:0] cause, input logic [63:0] res,
                           input logic [4:0] rd, input logic wb, input logic [31:0] ea);
        chk({tag, "_exc"}, 64'(exc), 64'(e.exc));
        if (e.exc) begin
            chk({tag, "_cause"}, 64'(cause), 64'(e.cause));
            chk({tag, "_exc_addr"}, 64'(ea), 64'(e.eaddr));
            chk({tag, "_wb_en"}, 64'(wb), 64'(0));
        end else begin
            chk({tag, "_wb_en"}, 64'(wb), 64'(e.wb));
            if (e.wb) begin
                chk({tag, "_rd"}, 64'(rd), 64'(e.rd));
                chk({tag, "_result"}, res, e.result);
            end
        end
    endtask

    // ---------------- XLEN=32 instance ----------------
    logic        a_rst, a_valid, a_flush, a_load, a_store, a_wb, a_ack;
    logic [2:0]  a_f3;
    logic [31:0] a_addr, a_res, a_wdata, a_rdata;
    logic [4:0]  a_rd;
    logic        a_stall, a_ovalid, a_owb, a_oexc, a_req, a_we;
    logic [31:0] a_ores, a_oeaddr, a_daddr, a_dwdata;
    logic [4:0]  a_ord;
    logic [3:0]  a_ocause, a_be;

    mem_stage_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(15)) dut32 (
        .i_clk(clk), .i_rst(a_rst), .i_valid(a_valid), .o_stall(a_stall), .i_flush(a_flush),
        .i_load(a_load), .i_store(a_store), .i_funct3(a_f3), .i_addr(a_addr),
        .i_result(a_res), .i_wdata(a_wdata), .i_rd_addr(a_rd), .i_wb_en(a_wb),
        .o_valid(a_ovalid), .o_result(a_ores), .o_rd_addr(a_ord), .o_wb_en(a_owb),
        .o_exc(a_oexc), .o_exc_cause(a_ocause), .o_exc_addr(a_oeaddr),
        .o_dmem_req(a_req), .o_dmem_we(a_we), .o_dmem_addr(a_daddr),
        .o_dmem_wdata(a_dwdata), .o_dmem_be(a_be), .i_dmem_ack(a_ack),
        .i_dmem_rdata(a_rdata)
    );

    // ---------------- XLEN=64 instance ----------------
    logic        b_rst, b_valid, b_flush, b_load, b_store, b_wb, b_ack;
    logic [2:0]  b_f3;
    logic [31:0] b_addr;
    logic [63:0] b_res, b_wdata, b_rdata;
    logic [4:0]  b_rd;
    logic        b_stall, b_ovalid, b_owb, b_oexc, b_req, b_we;
    logic [63:0] b_ores, b_dwdata;
    logic [31:0] b_oeaddr, b_daddr;
    logic [4:0]  b_ord;
    logic [3:0]  b_ocause;
    logic [7:0]  b_be;

    mem_stage_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(15)) dut64 (
        .i_clk(clk), .i_rst(b_rst), .i_valid(b_valid), .o_stall(b_stall), .i_flush(b_flush),
        .i_load(b_load), .i_store(b_store), .i_funct3(b_f3), .i_addr(b_addr),
        .i_result(b_res), .i_wdata(b_wdata), .i_rd_addr(b_rd), .i_wb_en(b_wb),
        .o_valid(b_ovalid), .o_result(b_ores), .o_rd_addr(b_ord), .o_wb_en(b_owb),
        .o_exc(b_oexc), .o_exc_cause(b_ocause), .o_exc_addr(b_oeaddr),
        .o_dmem_req(b_req), .o_dmem_we(b_we), .o_dmem_addr(b_daddr),
        .o_dmem_wdata(b_dwdata), .o_dmem_be(b_be), .i_dmem_ack(b_ack),
        .i_dmem_rdata(b_rdata)
    );

    // ---------------- result monitors (scoreboard side) ----------------
    always @(negedge clk) begin
        if (a_oexc && !a_ovalid) begin
            checks++; errors++;
            $display("FAIL a_exc_without_valid: got exc=1 valid=0 expected exc=0");
        end
        if (a_ovalid) begin
            if (a_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_valid: got o_valid=1 expected o_valid=0");
            end else begin
                a_e = a_q.pop_front();
                cmp_out("a", a_e, a_oexc, a_ocause, 64'(a_ores), a_ord, a_owb, a_oeaddr);
            end
        end
    end

    always @(negedge clk) begin
        if (b_oexc && !b_ovalid) begin
            checks++; errors++;
            $display("FAIL b_exc_without_valid: got exc=1 valid=0 expected exc=0");
        end
        if (b_ovalid) begin
            if (b_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_valid: got o_valid=1 expected o_valid=0");
            end else begin
                b_e = b_q.pop_front();
                cmp_out("b", b_e, b_oexc, b_ocause, b_ores, b_ord, b_owb, b_oeaddr);
            end
        end
    end

    // ---------------- bus responders ----------------
    int          a_ack_after = 0, a_req_cycles = 0, a_stall_n = 0, a_flush_at = 0;
    bit          a_bus_chk = 0;
    logic [31:0] a_rdata_v = '0, a_x_addr = '0, a_x_wdata = '0;
    logic [3:0]  a_x_be = '0;
    logic        a_x_we = 1'b0;

    always @(negedge clk) begin
        a_ack = 1'b0;
        if (a_req) begin
            a_req_cycles++;
            if (a_bus_chk) begin
                chk("a_dmem_addr", 64'(a_daddr), 64'(a_x_addr));
                chk("a_dmem_be", 64'(a_be), 64'(a_x_be));
                chk("a_dmem_we", 64'(a_we), 64'(a_x_we));
                if (a_x_we) chk("a_dmem_wdata", 64'(a_dwdata), 64'(a_x_wdata));
            end
            if (a_ack_after != 0 && a_req_cycles == a_ack_after) begin
                a_ack   = 1'b1;
                a_rdata = a_rdata_v;
            end
        end
    end

    int          b_ack_after = 0, b_req_cycles = 0, b_stall_n = 0;
    bit          b_bus_chk = 0;
    logic [63:0] b_rdata_v = '0;
    logic [31:0] b_x_addr = '0;
    logic [7:0]  b_x_be = '0;

    always @(negedge clk) begin
        b_ack = 1'b0;
        if (b_req) begin
            b_req_cycles++;
            if (b_bus_chk) begin
                chk("b_dmem_addr", 64'(b_daddr), 64'(b_x_addr));
                chk("b_dmem_be", 64'(b_be), 64'(b_x_be));
            end
            if (b_ack_after != 0 && b_req_cycles == b_ack_after) begin
                b_ack   = 1'b1;
                b_rdata = b_rdata_v;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic a_issue(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] res,
                           input logic [31:0] wd, input logic [4:0] rd, input logic wb);
        int n;
        a_req_cycles = 0;
        a_valid = 1'b1; a_load = ld; a_store = st; a_f3 = f3; a_addr = addr;
        a_res = res; a_wdata = wd; a_rd = rd; a_wb = wb;
        @(negedge clk);
        a_valid = 1'b0; a_load = 1'b0; a_store = 1'b0;
        n = 0;
        while (a_stall && n < 40) begin
            n++;
            a_flush = (n == a_flush_at);
            @(negedge clk);
        end
        a_flush = 1'b0;
        if (n >= 40) chk("a_stall_bound", 64'(n), 64'(0));
        a_stall_n = n;
    endtask

    task automatic b_issue(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] rd);
        int n;
        b_req_cycles = 0;
        b_valid = 1'b1; b_load = ld; b_store = 1'b0; b_f3 = f3; b_addr = addr;
        b_rd = rd; b_wb = 1'b1;
        @(negedge clk);
        b_valid = 1'b0; b_load = 1'b0;
        n = 0;
        while (b_stall && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n >= 40) chk("b_stall_bound", 64'(n), 64'(0));
        b_stall_n = n;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        a_valid = 0; a_flush = 0; a_load = 0; a_store = 0; a_f3 = 0; a_addr = 0;
        a_res = 0; a_wdata = 0; a_rd = 0; a_wb = 0; a_ack = 0; a_rdata = 0;
        b_valid = 0; b_flush = 0; b_load = 0; b_store = 0; b_f3 = 0; b_addr = 0;
        b_res = 0; b_wdata = 0; b_rd = 0; b_wb = 0; b_ack = 0; b_rdata = 0;
        a_rst = 1; b_rst = 1;
        repeat (2) @(negedge clk);
        a_rst = 0; b_rst = 0;

        // Reset state
        chk("rst_valid", 64'(a_ovalid), 64'(0));
        chk("rst_stall", 64'(a_stall), 64'(0));
        chk("rst_req", 64'(a_req), 64'(0));
        chk("rst_be", 64'(a_be), 64'(0));
        chk("rst_result", 64'(a_ores), 64'(0));
        chk("rst_b_req", 64'(b_req), 64'(0));

        // Pass-through
        a_q.push_back(mk(0, 0, 64'hDEADBEEF, 5, 1, 0));
        a_issue(0, 0, 3'b010, 32'h0, 32'hDEADBEEF, 32'h0, 5, 1);
        chk("pt_stall", 64'(a_stall_n), 64'(0));

        // LB / LBU at lane 3
        a_bus_chk = 1; a_x_addr = 32'h100; a_x_be = 4'b1000; a_x_we = 0;
        a_ack_after = 4; a_rdata_v = 32'h80AABBCC;
        a_q.push_back(mk(0, 0, 64'hFFFFFF80, 7, 1, 0));
        a_issue(1, 0, 3'b000, 32'h103, 0, 0, 7, 1);
        chk("lb_stall", 64'(a_stall_n), 64'(4));
        a_q.push_back(mk(0, 0, 64'h00000080, 7, 1, 0));
        a_issue(1, 0, 3'b100, 32'h103, 0, 0, 7, 1);
        chk("lbu_req_cycles", 64'(a_req_cycles), 64'(4));

        // SH at lane 2
        a_x_addr = 32'h200; a_x_be = 4'b1100; a_x_we = 1; a_x_wdata = 32'h12341234;
        a_ack_after = 1;
        a_q.push_back(mk(0, 0, 0, 3, 0, 0));
        a_issue(0, 1, 3'b001, 32'h202, 0, 32'h00001234, 3, 1);
        chk("sh_stall", 64'(a_stall_n), 64'(1));

        // Misaligned and illegal
        a_bus_chk = 0;
        a_q.push_back(mk(1, 4, 0, 0, 0, 32'h201));
        a_issue(1, 0, 3'b010, 32'h201, 0, 0, 4, 1);
        chk("lw_mis_req", 64'(a_req_cycles), 64'(0));
        a_q.push_back(mk(1, 6, 0, 0, 0, 32'h202));
        a_issue(0, 1, 3'b010, 32'h202, 0, 0, 4, 1);
        chk("sw_mis_stall", 64'(a_stall_n), 64'(0));
        a_q.push_back(mk(1, 2, 0, 0, 0, 32'h100));
        a_issue(1, 0, 3'b011, 32'h100, 0, 0, 4, 1);
        chk("ld32_req", 64'(a_req_cycles), 64'(0));

        // Watchdog: no ack, then ack on the last allowed cycle
        a_bus_chk = 1; a_x_addr = 32'h400; a_x_be = 4'b1111; a_x_we = 0;
        a_ack_after = 0;
        a_q.push_back(mk(1, 5, 0, 0, 0, 32'h400));
        a_issue(1, 0, 3'b010, 32'h400, 0, 0, 9, 1);
        chk("to_req_cycles", 64'(a_req_cycles), 64'(15));
        a_ack_after = 15; a_rdata_v = 32'h11223344;
        a_q.push_back(mk(0, 0, 64'h11223344, 9, 1, 0));
        a_issue(1, 0, 3'b010, 32'h400, 0, 0, 9, 1);
        chk("ack15_req_cycles", 64'(a_req_cycles), 64'(15));
        a_x_addr = 32'h500; a_x_we = 1; a_x_wdata = 32'hCAFEF00D; a_ack_after = 0;
        a_q.push_back(mk(1, 7, 0, 0, 0, 32'h500));
        a_issue(0, 1, 3'b010, 32'h500, 0, 32'hCAFEF00D, 9, 1);

        // Flush mid-WAIT: transaction completes, result suppressed
        a_bus_chk = 0; a_ack_after = 3; a_flush_at = 2;
        a_issue(1, 0, 3'b010, 32'h300, 0, 0, 6, 1);
        a_flush_at = 0;
        chk("flush_req_cycles", 64'(a_req_cycles), 64'(3));
        chk("flush_valid", 64'(a_ovalid), 64'(0));

        // Flush in IDLE: op not accepted
        a_valid = 1; a_flush = 1; a_res = 32'h55; a_rd = 2; a_wb = 1;
        @(negedge clk);
        a_valid = 0; a_flush = 0;
        chk("idle_flush_valid", 64'(a_ovalid), 64'(0));
        chk("idle_flush_stall", 64'(a_stall), 64'(0));

        // Reset during WAIT abandons the request
        a_ack_after = 0;
        a_valid = 1; a_load = 1; a_f3 = 3'b010; a_addr = 32'h600;
        @(negedge clk);
        a_valid = 0; a_load = 0;
        chk("wait_req_up", 64'(a_req), 64'(1));
        @(negedge clk);
        a_rst = 1;
        @(negedge clk);
        a_rst = 0;
        chk("rst_wait_req", 64'(a_req), 64'(0));
        chk("rst_wait_stall", 64'(a_stall), 64'(0));

        // XLEN=64 loads
        b_bus_chk = 1; b_ack_after = 1; b_rdata_v = 64'h0123456789ABCDEF;
        b_x_addr = 32'h8; b_x_be = 8'hFF;
        b_q.push_back(mk(0, 0, 64'h0123456789ABCDEF, 1, 1, 0));
        b_issue(1, 3'b011, 32'h8, 1);
        b_x_be = 8'hF0;
        b_q.push_back(mk(0, 0, 64'h0000000001234567, 2, 1, 0));
        b_issue(1, 3'b110, 32'hC, 2);
        b_x_be = 8'h0F;
        b_q.push_back(mk(0, 0, 64'hFFFFFFFF89ABCDEF, 3, 1, 0));
        b_issue(1, 3'b010, 32'h8, 3);
        chk("b_lw_stall", 64'(b_stall_n), 64'(1));
        b_bus_chk = 0;
        b_q.push_back(mk(1, 4, 0, 0, 0, 32'hC));
        b_issue(1, 3'b011, 32'hC, 4);
        chk("b_ld_mis_req", 64'(b_req_cycles), 64'(0));

        repeat (3) @(negedge clk);
        chk("a_q_drained", 64'(a_q.size()), 64'(0));
        chk("b_q_drained", 64'(b_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised successor to the CPU memory stage.
- Accepts one op per handshake from execute: load, store, or pass-through ALU result.
- Drives a single-outstanding valid/ack data-memory bus with byte enables and sign/zero extension of load data.
- Raises precise misaligned and access-fault exceptions, with mcause codes, to the Zicsr trap logic.
- Supports XLEN 32/64 and a bus-timeout watchdog.

Parameters:
- XLEN, 32, data width; legal values 32 or 64.
- ADDR_W, 32, byte address width.
- TIMEOUT, 15, cycles in WAIT without ack before an access fault; 0 disables the watchdog.

Ports:
- i_clk  in  1  CPU clock.
- i_rst  in  1  reset; one clock; reset is synchronous and active-high.
- i_valid  in  1  execute presents an op.
- o_stall  out  1  = (state != IDLE); upstream holds its inputs while high.
- i_flush  in  1  trap/redirect; kills the current or in-flight result.
- i_load, i_store  in  1 each  op type; both low = pass-through; both high is illegal (treated as pass-through).
- i_funct3  in  3  RV width/sign: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only).
- i_addr  in  ADDR_W  effective byte address.
- i_result  in  XLEN  ALU result for pass-through.
- i_wdata  in  XLEN  store data (rs2).
- i_rd_addr  in  5;  i_wb_en  in  1.
- o_valid  out  1;  o_result  out  XLEN;  o_rd_addr  out  5;  o_wb_en  out  1.
- o_exc  out  1;  o_exc_cause  out  4;  o_exc_addr  out  ADDR_W (mtval).
- o_dmem_req  out  1;  o_dmem_we  out  1.
- o_dmem_addr  out  ADDR_W: address aligned down to XLEN/8.
- o_dmem_wdata  out  XLEN;  o_dmem_be  out  XLEN/8.
- i_dmem_ack  in  1;  i_dmem_rdata  in  XLEN.

Behaviour:
- Reset: state=IDLE; all outputs 0; timeout counter 0.
- FSM IDLE/WAIT. Ops are accepted only when state=IDLE and i_valid=1.
- Pass-through op: next cycle o_valid=1, o_result=i_result, o_rd_addr/o_wb_en registered. Latency 1.
- Alignment check, with lane offset off = i_addr[log2(XLEN/8)-1:0]:
  - H requires off[0]=0; W requires off[1:0]=0; D requires off[2:0]=0.
  - On violation: no bus request; next cycle o_valid=1, o_wb_en=0, o_exc=1, o_exc_addr=i_addr.
  - o_exc_cause = 4 for a load, 6 for a store.
- funct3 011/110 with XLEN=32, and funct3 111, are treated as illegal: same path, cause 2.
- Aligned mem op: go to WAIT.
  - o_dmem_req=1 from the next cycle, held with stable addr/we/be/wdata until the cycle i_dmem_ack=1.
  - Stores: wdata is replicated into lanes, be = size mask << off.
  - Loads: be = size mask << off as well.
- On ack in WAIT: req drops the same edge; state to IDLE.
  - Next cycle o_valid=1.
  - Loads: o_result = rdata shifted right by off*8, truncated to size, sign- or zero-extended to XLEN; o_wb_en = registered i_wb_en.
  - Stores: o_wb_en=0.
  - Minimum mem-op latency is 2 cycles (ack on the first req cycle).
- Watchdog (TIMEOUT>0):
  - Counter clears on entering WAIT and increments each WAIT cycle without ack.
  - When the count reaches TIMEOUT: drop req, go to IDLE; next cycle o_valid=1, o_exc=1, cause 5 (load) or 7 (store), o_exc_addr=address.
  - Ack in the same cycle as the timeout wins (normal completion).
- o_valid is a one-cycle pulse; o_exc is only ever high together with o_valid.
- i_flush:
  - In IDLE: no op is accepted that cycle and next-cycle o_valid=0.
  - In WAIT: the bus transaction completes normally (req held until ack or timeout) but its o_valid/o_exc are suppressed.
  - i_flush has no effect on the cycle its result is already being presented.
- i_rst during WAIT: req drops at the next edge; the transaction is abandoned (the bus must tolerate this).

Test Plan:
- Reset, then pass-through i_result=0xDEADBEEF, rd=5, wb_en=1 -> next cycle o_valid=1, o_result=0xDEADBEEF, o_rd_addr=5; o_stall never asserted.
- LB addr=0x103, ack after 3 cycles with rdata=0x80AABBCC -> be=1000, o_dmem_addr=0x100, o_stall high 4 cycles, o_result=0xFFFFFF80. Repeat with LBU -> 0x00000080.
- SH addr=0x202, wdata=0x1234 -> o_dmem_we=1, be=1100, wdata=0x12341234, o_wb_en=0 on completion.
- LW addr=0x201 -> no o_dmem_req; next cycle o_exc=1, cause=4, o_exc_addr=0x201. SW addr=0x202 -> cause=6.
- TIMEOUT=15, load with ack never asserted -> req high exactly 15 cycles, then o_exc=1, cause=5. Second run with ack on cycle 15 -> normal completion, no exception.
- XLEN=64: LD addr=0x8, rdata=0x0123456789ABCDEF -> result unchanged. LWU addr=0xC -> 0x0000000001234567. With XLEN=32, funct3=011 -> cause 2. Also assert i_flush mid-WAIT -> ack completes, o_valid stays 0.
